// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter using shift-add-3, one bit per clock.
// Feeds packed digits and a leading-zero blank mask to the display scanner.
module bin2bcd_seq #(
    parameter int BIN_W  = 27,
    parameter int DIGITS = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [BIN_W-1:0]      bin_in,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd_out,
    output logic [DIGITS-1:0]     lz_mask,
    output logic                  ovf
);

    localparam int BCD_W = 4 * DIGITS;
    localparam int CW    = $clog2(BIN_W + 1);

    function automatic logic [63:0] max_val();
        logic [63:0] r;
        r = 64'd1;
        for (int i = 0; i < DIGITS; i++) r = r * 64'd10;
        return r - 64'd1;
    endfunction

    localparam logic [63:0] MAX_VAL = max_val();

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t            state;
    logic [BIN_W-1:0]  binreg;
    logic [BCD_W-1:0]  scratch;
    logic [CW-1:0]     count;
    logic              ovf_pending;

    logic [BCD_W-1:0]  adj;
    logic [BCD_W-1:0]  final_bcd;
    logic [DIGITS-1:0] lz_next;
    logic              all_zero;

    always_comb begin
        adj = scratch;
        for (int i = 0; i < DIGITS; i++) begin
            if (scratch[4*i +: 4] >= 4'd5)
                adj[4*i +: 4] = scratch[4*i +: 4] + 4'd3;
        end
    end

    // Overflow saturates the display to all nines.
    always_comb begin
        final_bcd = ovf_pending ? {DIGITS{4'h9}} : scratch;
        lz_next   = '0;
        all_zero  = 1'b1;
        for (int i = DIGITS - 1; i > 0; i--) begin
            all_zero   = all_zero & (final_bcd[4*i +: 4] == 4'd0);
            lz_next[i] = all_zero;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            binreg      <= '0;
            scratch     <= '0;
            count       <= '0;
            ovf_pending <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            bcd_out     <= '0;
            lz_mask     <= {{(DIGITS-1){1'b1}}, 1'b0};
            ovf         <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        binreg      <= bin_in;
                        scratch     <= '0;
                        count       <= CW'(BIN_W);
                        ovf_pending <= (64'(bin_in) > MAX_VAL);
                        busy        <= 1'b1;
                        state       <= SHIFT;
                    end
                end
                SHIFT: begin
                    scratch <= {adj[BCD_W-2:0], binreg[BIN_W-1]};
                    binreg  <= {binreg[BIN_W-2:0], 1'b0};
                    count   <= count - 1'b1;
                    if (count == CW'(1))
                        state <= DONE;
                end
                DONE: begin
                    bcd_out <= final_bcd;
                    lz_mask <= lz_next;
                    ovf     <= ovf_pending;
                    done    <= 1'b1;
                    busy    <= 1'b0;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
